// File: rtl/serialize_pkg.sv
// Shared helpers for the serialize_queue slice: element selection out of a packed wide word.
package serialize_pkg;

  localparam int unsigned MAX_WORD_BITS = 1024;
  localparam int unsigned MAX_ELEM_BITS = 64;

  typedef logic [MAX_WORD_BITS-1:0] word_t;
  typedef logic [MAX_ELEM_BITS-1:0] elem_t;

  // Caller zero-extends its word into word_t and truncates the result to its element width.
  function automatic elem_t elem_sel(input word_t data, input int unsigned idx,
                                     input int unsigned w_data);
    return elem_t'(data >> (idx * w_data));
  endfunction

endpackage

// File: rtl/serialize_oreg.sv
// One-entry pipeline register with ready/valid; breaks the combinational path on dout.valid.
module serialize_oreg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         load_en,
  output logic         load,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         ovalid_q, ovalid_d;
  logic [W-1:0] odata_q, odata_d;

  always_comb begin
    load_en  = ~ovalid_q | out_ready;
    load     = in_valid & load_en;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    if (load) begin
      ovalid_d = 1'b1;
      odata_d  = in_data;
    end else if (out_ready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ovalid_q <= 1'b0;
    else     ovalid_q <= ovalid_d;
  end

  // Data needs no reset: it is only observed while ovalid_q is set.
  always_ff @(posedge clk) begin
    odata_q <= odata_d;
  end

  assign out_valid = ovalid_q;
  assign out_data  = odata_q;

endmodule

// File: rtl/serialize_queue.sv
// Serializes one wide word of up to NUM packed elements into Queue beats {eot, elem}, element 0 first.
module serialize_queue
  import serialize_pkg::*;
#(
  parameter int  W_DATA  = 16,
  parameter int  NUM     = 4,
  parameter bit  REG_OUT = 1'b1,
  localparam int W_LEN   = $clog2(NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W_LEN+NUM*W_DATA-1:0]   din_data,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [W_DATA:0]               dout_data,
  output logic                          dout_valid,
  input  logic                          dout_ready
);

  typedef struct packed {
    logic              eot;
    logic [W_DATA-1:0] data;
  } beat_t;

  localparam logic [W_LEN-1:0] LEN_MAX = W_LEN'(NUM - 1);

  logic [W_LEN-1:0] len, len_eff;
  logic [W_LEN-1:0] idx_q, idx_d;
  logic             last;
  logic             adv;
  beat_t            beat;

  assign len = din_data[W_LEN+NUM*W_DATA-1 -: W_LEN];

  // Out-of-range lengths (only possible when NUM is not a power of two) end at the last element.
  always_comb begin
    len_eff   = (int'(len) > NUM - 1) ? LEN_MAX : len;
    last      = (idx_q == len_eff);
    beat.eot  = last;
    beat.data = W_DATA'(elem_sel(word_t'(din_data[NUM*W_DATA-1:0]), 32'(idx_q), W_DATA));
    idx_d     = idx_q;
    if (adv) idx_d = last ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic load, load_en;

      serialize_oreg #(.W(W_DATA + 1)) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (din_valid),
        .in_data   (beat),
        .out_ready (dout_ready),
        .load_en   (load_en),
        .load      (load),
        .out_valid (dout_valid),
        .out_data  (dout_data)
      );

      assign adv       = load;
      assign din_ready = load_en & last;
    end else begin : g_comb_out
      assign dout_valid = din_valid;
      assign dout_data  = beat;
      assign adv        = din_valid & dout_ready;
      // The word is released only together with its final beat.
      assign din_ready  = dout_ready & last;
    end
  endgenerate

endmodule

// File: tb/tb_serialize_queue.sv
// Directed bench for serialize_queue: combinational (index 0) and registered (index 1) variants side by side.
module tb_serialize_queue;

  logic        clk;
  logic        rst;
  logic [33:0] din_data   [2];
  logic        din_valid  [2];
  logic        din_ready  [2];
  logic [8:0]  dout_data  [2];
  logic        dout_valid [2];
  logic        dout_ready [2];

  int n_chk;
  int n_err;
  int consume_cyc;
  logic rdy_pat [256];

  serialize_queue #(.W_DATA(8), .NUM(4), .REG_OUT(1'b0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .din_data   (din_data[0]),
    .din_valid  (din_valid[0]),
    .din_ready  (din_ready[0]),
    .dout_data  (dout_data[0]),
    .dout_valid (dout_valid[0]),
    .dout_ready (dout_ready[0])
  );

  serialize_queue #(.W_DATA(8), .NUM(4), .REG_OUT(1'b1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .din_data   (din_data[1]),
    .din_valid  (din_valid[1]),
    .din_ready  (din_ready[1]),
    .dout_data  (dout_data[1]),
    .dout_valid (dout_valid[1]),
    .dout_ready (dout_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_at(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 2) == 1;
      2:       return rdy_pat[cyc % 256];
      default: return 1'b1;
    endcase
  endfunction

  // Presents words in order, collects beats and compares them with the expected sequence.
  task automatic run_stream(input int k, input logic [33:0] words[$], input logic [8:0] exp_beats[$],
                            input int exp_cyc[$], input int mode, input string tag);
    int         wi, cyc, nb;
    logic       prev_stall;
    logic [8:0] prev_data;
    wi = 0; cyc = 0; nb = 0; prev_stall = 1'b0; prev_data = '0;
    while (nb < exp_beats.size() && cyc < 400) begin
      @(posedge clk); #1;
      rst           = 1'b0;
      din_valid[k]  = (wi < words.size());
      din_data[k]   = (wi < words.size()) ? words[wi] : '0;
      dout_ready[k] = ready_at(mode, cyc);
      #1;
      if (prev_stall) chk({tag, "_hold"}, 32'(dout_data[k]), 32'(prev_data));
      prev_stall = dout_valid[k] & ~dout_ready[k];
      prev_data  = dout_data[k];
      if (dout_valid[k] && dout_ready[k]) begin
        chk({tag, "_beat"}, 32'(dout_data[k]), 32'(exp_beats[nb]));
        if (exp_cyc.size() > 0) chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc[nb]));
        nb++;
      end
      if (din_valid[k] && din_ready[k]) begin
        wi++;
        consume_cyc = cyc;
      end
      cyc++;
    end
    chk({tag, "_nbeats"}, 32'(nb), 32'(exp_beats.size()));
    chk({tag, "_nwords"}, 32'(wi), 32'(words.size()));
    @(posedge clk); #1;
    din_valid[k]  = 1'b0;
    dout_ready[k] = 1'b1;
    #1;
    chk({tag, "_idle"}, 32'(dout_valid[k]), 32'd0);
  endtask

  initial begin
    logic [33:0] words[$];
    logic [8:0]  beats[$];
    int          cycs[$];
    int          none[$];
    logic [33:0] w1;
    logic [31:0] d;
    logic [1:0]  len;
    int          nbt;

    n_chk = 0; n_err = 0; consume_cyc = -1;
    w1 = {2'd3, 32'h44332211};
    for (int i = 0; i < 256; i++) rdy_pat[i] = 1'($urandom_range(0, 1));
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din_valid[k] = 1'b0; din_data[k] = w1; dout_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", 32'(dout_valid[0]), 32'd0);
    chk("rst_valid1", 32'(dout_valid[1]), 32'd0);
    chk("rst_data0_idx0", 32'(dout_data[0]), 32'h011);
    chk("rst_ready0", 32'(din_ready[0]), 32'd0);

    for (int k = 0; k < 2; k++) begin
      // Full four-element word
      words = '{w1};
      beats = '{9'h011, 9'h022, 9'h033, 9'h144};
      cycs  = '{k, k + 1, k + 2, k + 3};
      run_stream(k, words, beats, cycs, 0, $sformatf("t1_r%0d", k));
      chk($sformatf("t1_r%0d_consume", k), 32'(consume_cyc), 32'd3);

      // Short words back to back
      words = '{{2'd1, 32'h44332211}, {2'd1, 32'h88776655}};
      beats = '{9'h011, 9'h122, 9'h055, 9'h166};
      cycs  = '{k, k + 1, k + 2, k + 3};
      run_stream(k, words, beats, cycs, 0, $sformatf("t2_r%0d", k));

      // Alternating backpressure
      words = '{w1};
      beats = '{9'h011, 9'h022, 9'h033, 9'h144};
      run_stream(k, words, beats, none, 1, $sformatf("t3_r%0d", k));

      // Long word then single-element word, no bubble
      words = '{{2'd3, 32'hDDCCBBAA}, {2'd0, 32'h000000EE}};
      beats = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD, 9'h1EE};
      cycs  = '{k, k + 1, k + 2, k + 3, k + 4};
      run_stream(k, words, beats, cycs, 0, $sformatf("t4_r%0d", k));

      // Reset after the second beat abandons the word; it restarts at element 0
      for (int c = 0; c < 2 + k; c++) begin
        @(posedge clk); #1;
        din_valid[k] = 1'b1; din_data[k] = w1; dout_ready[k] = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      words = '{w1};
      beats = '{9'h011, 9'h022, 9'h033, 9'h144};
      cycs  = '{k, k + 1, k + 2, k + 3};
      run_stream(k, words, beats, cycs, 0, $sformatf("t5_r%0d", k));
    end

    // Random words: both variants against the same model, unstalled then with random ready
    words.delete(); beats.delete();
    for (int j = 0; j < 6; j++) begin
      len = 2'($urandom_range(0, 3));
      d   = $urandom;
      words.push_back({len, d});
      for (int e = 0; e <= int'(len); e++) beats.push_back({(e == int'(len)), d[8*e +: 8]});
    end
    nbt = beats.size();
    for (int k = 0; k < 2; k++) begin
      cycs.delete();
      for (int i = 0; i < nbt; i++) cycs.push_back(i + k);
      run_stream(k, words, beats, cycs, 0, $sformatf("t6_r%0d", k));
      run_stream(k, words, beats, none, 2, $sformatf("t6s_r%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
